// File: rtl/or32x1_pkg.sv
// or32x1 shared definitions
// Widths and the combined-vector type.
package or32x1_pkg;
  localparam int HALF_W = 16;
  localparam int VEC_W  = 2 * HALF_W;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 6;

  typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/or32x1_scan.sv
// or32x1 combinational scan
// OR, lowest set bit and popcount of one vector.
module or32x1_scan
  import or32x1_pkg::*;
(
  input  vec_t             v,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] cnt
);

  // Downward scan so the last hit is the lowest bit.
  always_comb begin
    any = |v;
    idx = '0;
    cnt = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    for (int i = 0; i < VEC_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
  end

endmodule

// File: rtl/or32x1_reg.sv
// or32x1 registered reduction top
// Qualifies input, registers scan results, keeps sticky flag.
module or32x1_reg
  import or32x1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [HALF_W-1:0] or_input0,
  input  logic [HALF_W-1:0] or_input1,
  input  logic              sticky_clr,
  output logic              or_output,
  output logic              out_valid,
  output logic [IDX_W-1:0]  set_index,
  output logic [CNT_W-1:0]  set_count,
  output logic              sticky_or
);

  vec_t             v;
  logic             any;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             set_ev;

  // Data gated by in_valid so idle X never reaches the scan.
  always_comb begin
    v      = in_valid ? {or_input1, or_input0} : '0;
    set_ev = in_valid & any;
  end

  or32x1_scan u_scan (
    .v   (v),
    .any (any),
    .idx (idx),
    .cnt (cnt)
  );

  // Result registers load on valid and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_output <= 1'b0;
      out_valid <= 1'b0;
      set_index <= '0;
      set_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        or_output <= any;
        set_index <= idx;
        set_count <= cnt;
      end
    end
  end

  // Sticky flag; a set event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_or <= 1'b0;
    end else if (set_ev) begin
      sticky_or <= 1'b1;
    end else if (sticky_clr) begin
      sticky_or <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or32x1_reg.sv
// or32x1_reg testbench
// Reference model plus directed literal checks.
module tb_or32x1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] or_input0;
  logic [15:0] or_input1;
  logic        sticky_clr;
  logic        or_output;
  logic        out_valid;
  logic [4:0]  set_index;
  logic [5:0]  set_count;
  logic        sticky_or;

  int errors = 0;
  int checks = 0;

  or32x1_reg dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .or_input0  (or_input0),
    .or_input1  (or_input1),
    .sticky_clr (sticky_clr),
    .or_output  (or_output),
    .out_valid  (out_valid),
    .set_index  (set_index),
    .set_count  (set_count),
    .sticky_or  (sticky_or)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  logic       m_or, m_ov, m_st;
  int         m_idx, m_cnt;
  logic [31:0] mv;

  assign mv = {or_input1, or_input0};

  // Reference model straight from the behavioural rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_or <= 0; m_ov <= 0; m_st <= 0; m_idx <= 0; m_cnt <= 0;
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        m_or  <= (mv != 0);
        m_idx <= lowest(mv);
        m_cnt <= $countones(mv);
      end
      if (in_valid && mv != 0) m_st <= 1;
      else if (sticky_clr)     m_st <= 0;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    chk("m_or",  32'(or_output), 32'(m_or));
    chk("m_ov",  32'(out_valid), 32'(m_ov));
    chk("m_idx", 32'(set_index), m_idx);
    chk("m_cnt", 32'(set_count), m_cnt);
    chk("m_st",  32'(sticky_or), 32'(m_st));
  end

  task automatic lit(input string nm, input int o, input int i,
                     input int c, input int ov, input int st);
    chk({nm, ".or"},  32'(or_output), o);
    chk({nm, ".idx"}, 32'(set_index), i);
    chk({nm, ".cnt"}, 32'(set_count), c);
    chk({nm, ".ov"},  32'(out_valid), ov);
    chk({nm, ".st"},  32'(sticky_or), st);
  endtask

  task automatic drv(input logic vl, input logic [15:0] a,
                     input logic [15:0] b, input logic cl);
    in_valid = vl; or_input0 = a; or_input1 = b; sticky_clr = cl;
  endtask

  initial begin
    rst = 1;
    drv(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    lit("reset", 0, 0, 0, 0, 0);
    rst = 0;
    drv(1, 16'h0000, 16'h0000, 0);
    @(negedge clk); lit("zero", 0, 0, 0, 1, 0);
    drv(1, 16'h0000, 16'h0001, 0);
    @(negedge clk); lit("bit16", 1, 16, 1, 1, 1);
    drv(1, 16'h0001, 16'h0000, 0);
    @(negedge clk); lit("bit0", 1, 0, 1, 1, 1);
    drv(1, 16'h0001, 16'h0001, 0);
    @(negedge clk); lit("b0b16", 1, 0, 2, 1, 1);
    drv(1, 16'hFFFF, 16'hFFFF, 0);
    @(negedge clk); lit("ones", 1, 0, 32, 1, 1);
    drv(0, 16'hxxxx, 16'hxxxx, 0);
    @(negedge clk); lit("hold", 1, 0, 32, 0, 1);
    drv(1, 16'h0000, 16'h0000, 1);
    @(negedge clk); lit("clr", 0, 0, 0, 1, 0);
    drv(1, 16'h0000, 16'h8000, 1);
    @(negedge clk); lit("setwin", 1, 31, 1, 1, 1);
    drv(1, 16'h0F00, 16'h00F0, 0);
    @(negedge clk); lit("mix", 1, 8, 8, 1, 1);
    drv(0, 16'h0000, 16'h0000, 1);
    @(negedge clk); lit("idleclr", 1, 8, 8, 0, 0);
    drv(1, 16'h0000, 16'h4000, 0);
    @(negedge clk); lit("bit30", 1, 30, 1, 1, 1);
    drv(0, 16'h0000, 16'h0000, 0);
    #2 rst = 1;
    #1 lit("async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk); lit("idle", 0, 0, 0, 0, 0);
    drv(1, 16'h0004, 16'h0000, 0);
    @(negedge clk); lit("first", 1, 2, 1, 1, 1);
    drv(0, 16'h0000, 16'h0000, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
